// File: rtl/vga_sync_decoder.sv
// Recovers line/frame timing from a VGA sync pair, acquires lock, emits visible pixels with x/y.
// Latency: outputs are registered, one cycle after the sample they describe; no backpressure.
// Optional saturating timing-error counter enabled by VGA_SYNC_DECODER_ERRCNT_EN.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_VIS_START = 144,
    parameter int V_VIS_START = 35,
    parameter int H_VIS       = 640,
    parameter int V_VIS       = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
);
    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_BEG   = 10'(H_VIS_START);
    localparam logic [9:0] H_END   = 10'(H_VIS_START + H_VIS);
    localparam logic [9:0] V_BEG   = 10'(V_VIS_START);
    localparam logic [9:0] V_END   = 10'(V_VIS_START + V_VIS);

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vpend_q, vpend_d;
    logic [1:0]  good_cnt_q, good_cnt_d;
    logic        de_q, de_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        fs_q, fs_d;

    logic hs_fall, vs_fall, frame_ev;
    logic line_err, tmo_err, frame_err, any_err;

    always_comb begin
        hs_prev_d = hsync;
        vs_prev_d = vsync;
        hs_fall   = hs_prev_q & ~hsync;
        vs_fall   = vs_prev_q & ~vsync;
        // A vsync fall arms the frame; the next hsync fall (possibly this one) starts it.
        frame_ev  = hs_fall & (vpend_q | vs_fall);

        if (hs_fall)
            hcnt_d = 10'd0;
        else if (hcnt_q == CNT_MAX)
            hcnt_d = CNT_MAX;
        else
            hcnt_d = hcnt_q + 10'd1;

        if (frame_ev)
            vcnt_d = 10'd0;
        else if (hs_fall && vcnt_q != CNT_MAX)
            vcnt_d = vcnt_q + 10'd1;
        else
            vcnt_d = vcnt_q;

        if (frame_ev)
            vpend_d = 1'b0;
        else if (vs_fall)
            vpend_d = 1'b1;
        else
            vpend_d = vpend_q;

        line_err  = hs_fall && (hcnt_q != H_LAST);
        tmo_err   = (hcnt_d == CNT_MAX) && (hcnt_q != CNT_MAX);
        frame_err = frame_ev && (vcnt_q != V_LAST);
        any_err   = line_err | tmo_err | frame_err;
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            SEARCH: begin
                good_cnt_d = 2'd0;
                if (frame_ev)
                    state_d = TRAIN;
            end
            TRAIN: begin
                if (any_err) begin
                    state_d    = SEARCH;
                    good_cnt_d = 2'd0;
                end else if (frame_ev) begin
                    good_cnt_d = good_cnt_q + 2'd1;
                    if (good_cnt_q == 2'd1)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d    = SEARCH;
                    good_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = 2'd0;
            end
        endcase
    end

    // Uses next state so an error exiting LOCKED blanks de in the same registered cycle.
    always_comb begin
        de_d  = (state_d == LOCKED) &&
                (hcnt_d >= H_BEG) && (hcnt_d < H_END) &&
                (vcnt_d >= V_BEG) && (vcnt_d < V_END);
        x_d   = de_d ? (hcnt_d - H_BEG) : 10'd0;
        y_d   = de_d ? (vcnt_d - V_BEG) : 10'd0;
        rgb_d = de_d ? rgb_in : 12'd0;
        fs_d  = de_d && (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            hs_prev_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            hcnt_q     <= 10'd0;
            vcnt_q     <= 10'd0;
            vpend_q    <= 1'b0;
            good_cnt_q <= 2'd0;
            de_q       <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            rgb_q      <= 12'd0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            vpend_q    <= vpend_d;
            good_cnt_q <= good_cnt_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rgb_q      <= rgb_d;
            fs_q       <= fs_d;
        end
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (any_err && (state_q != SEARCH) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_cnt_q <= 8'd0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign rgb_out     = rgb_q;
    assign frame_start = fs_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster; per-cycle reference model plus directed scenarios.
module tb_vga_sync_decoder;
    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HVS = 8;
    localparam int VVS = 3;
    localparam int HV  = 24;
    localparam int VV  = 12;
    localparam int HSW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] rgb_in = 12'd0;
    logic        de, frame_start, locked;
    logic [9:0]  x, y;
    logic [11:0] rgb_out;
    logic [7:0]  err_cnt;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_VIS_START(HVS), .V_VIS_START(VVS),
        .H_VIS(HV), .V_VIS(VV)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .de(de), .x(x), .y(y), .rgb_out(rgb_out), .frame_start(frame_start),
        .locked(locked), .err_cnt(err_cnt)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    // Reference model: plain integer counters; stage 0 = searching, 1..2 = clean frames seen, 3 = locked.
    bit  m_ph, m_pv, m_pend, m_fev;
    int  m_h, m_v, m_stage, m_err;
    int  fev_cnt;
    logic [42:0] exp_v;

    task automatic model_step();
        bit hf, vf, le, te, fe, any, vis;
        int nh, nv;
        m_fev = 1'b0;
        if (reset) begin
            m_ph = 1; m_pv = 1; m_pend = 0; m_h = 0; m_v = 0; m_stage = 0; m_err = 0;
            exp_v = '0;
        end else begin
            hf = m_ph && !hsync;
            vf = m_pv && !vsync;
            m_fev = hf && (m_pend || vf);
            nh = hf ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
            nv = m_fev ? 0 : (hf ? ((m_v < 1023) ? m_v + 1 : 1023) : m_v);
            le = hf && (m_h != HT - 1);
            te = (nh == 1023) && (m_h != 1023);
            fe = m_fev && (m_v != VT - 1);
            any = le || te || fe;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
            if (m_stage != 0 && any && m_err < 255) m_err++;
`endif
            if (m_stage == 0) begin
                if (m_fev) m_stage = 1;
            end else if (any) begin
                m_stage = 0;
            end else if (m_fev && m_stage < 3) begin
                m_stage++;
            end
            vis = (m_stage == 3) && (nh >= HVS) && (nh < HVS + HV) && (nv >= VVS) && (nv < VVS + VV);
            exp_v = {vis, vis ? 10'(nh - HVS) : 10'd0, vis ? 10'(nv - VVS) : 10'd0,
                     vis ? rgb_in : 12'd0, vis && (nh == HVS) && (nv == VVS),
                     m_stage == 3, 8'(m_err)};
            m_pend = m_fev ? 1'b0 : (vf ? 1'b1 : m_pend);
            m_h = nh; m_v = nv; m_ph = hsync; m_pv = vsync;
            if (m_fev) fev_cnt++;
        end
    endtask

    task automatic cyc(input bit h, input bit v, input bit rst);
        logic [42:0] got;
        hsync  = h;
        vsync  = v;
        reset  = rst;
        rgb_in = 12'($urandom);
        model_step();
        @(posedge clk);
        #1;
        cyc_no++;
        got = {de, x, y, rgb_out, frame_start, locked, err_cnt};
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL model cycle %0d: got de=%b x=%0d y=%0d rgb=%h fs=%b lk=%b err=%0d, expected %h",
                     cyc_no, de, x, y, rgb_out, frame_start, locked, err_cnt, exp_v);
        end
    endtask

    // vmode: 0 high, 1 low, 2 falls mid-line, 3 low for the first two clocks
    task automatic line(input int len, input int vmode);
        bit v;
        for (int i = 0; i < len; i++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = 1'b0;
                2:       v = (i < len / 2);
                default: v = (i >= 2);
            endcase
            cyc(i >= HSW, v, 1'b0);
        end
    endtask

    task automatic frame(input bit late_vs);
        for (int l = 0; l < VT; l++) begin
            if (late_vs) line(HT, (l == 0) ? 2 : ((l == 1) ? 1 : 0));
            else         line(HT, (l < 2) ? 1 : 0);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({de, x, y, rgb_out, frame_start, locked, err_cnt} !== 43'd0) begin
            n_fail++;
            $display("FAIL %s: outputs de=%b x=%0d y=%0d rgb=%h fs=%b lk=%b err=%0d, required all 0",
                     name, de, x, y, rgb_out, frame_start, locked, err_cnt);
        end
    endtask

    task automatic check_lock(input string name, input bit want);
        n_tests++;
        if (locked !== want) begin
            n_fail++;
            $display("FAIL %s: locked=%b, required %b", name, locked, want);
        end
    endtask

    function automatic int err_step(input int base);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        return (base < 255) ? base + 1 : 255;
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1);
        check_zero("reset_state");
    endtask

    task automatic test_lock();
        int de_n, fs_n;
        bit prev_lk;
        de_n = 0; fs_n = 0; prev_lk = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        fev_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < VT; l++) begin
                for (int i = 0; i < HT; i++) begin
                    cyc(i >= HSW, l >= 2, 1'b0);
                    if (m_fev && fev_cnt == 3) begin
                        n_tests++;
                        if (!(locked === 1'b1 && prev_lk === 1'b0)) begin
                            n_fail++;
                            $display("FAIL lock_timing: locked=%b prev=%b, required 1 after 0", locked, prev_lk);
                        end
                    end
                    if (f == 3) begin
                        if (de === 1'b1) de_n++;
                        if (frame_start === 1'b1) begin
                            fs_n++;
                            n_tests++;
                            if (!(de === 1'b1 && x === 10'd0 && y === 10'd0)) begin
                                n_fail++;
                                $display("FAIL frame_start_xy: de=%b x=%0d y=%0d, required 1,0,0", de, x, y);
                            end
                        end
                    end
                    prev_lk = locked;
                end
            end
        end
        n_tests++;
        if (de_n != HV * VV) begin
            n_fail++;
            $display("FAIL de_count: %0d de cycles, required %0d", de_n, HV * VV);
        end
        n_tests++;
        if (fs_n != 1) begin
            n_fail++;
            $display("FAIL frame_start_count: %0d pulses, required 1", fs_n);
        end
    endtask

    task automatic test_coincident();
        bit stayed;
        stayed = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < VT; l++)
                for (int i = 0; i < HT; i++) begin
                    cyc(i >= HSW, l >= 2, 1'b0);
                    if (m_fev && locked !== 1'b1) stayed = 1'b0;
                end
        end
        n_tests++;
        if (!stayed) begin
            n_fail++;
            $display("FAIL coincident_frame: lock dropped at a coincident frame event, required held");
        end
    endtask

    task automatic test_short_line();
        int e0;
        e0 = err_cnt;
        check_lock("short_line_pre", 1'b1);
        for (int l = 0; l < 5; l++) line(HT, (l < 2) ? 1 : 0);
        line(HT - 1, 0);
        cyc(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (!(locked === 1'b0 && de === 1'b0 && err_cnt === 8'(err_step(e0)))) begin
            n_fail++;
            $display("FAIL short_line: locked=%b de=%b err=%0d, required 0 0 %0d", locked, de, err_cnt, err_step(e0));
        end
        for (int i = 1; i < HT; i++) cyc(i >= HSW, 1'b1, 1'b0);
        for (int l = 7; l < VT; l++) line(HT, 0);
        frame(1'b0);
        frame(1'b0);
        check_lock("relock_too_early", 1'b0);
        frame(1'b0);
        check_lock("relock", 1'b1);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        for (int k = 0; k < 1100; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (k == 982) check_lock("timeout_pre", 1'b1);
            if (k == 983) begin
                n_tests++;
                if (!(locked === 1'b0 && err_cnt === 8'(err_step(e0)))) begin
                    n_fail++;
                    $display("FAIL timeout_edge: locked=%b err=%0d, required 0 %0d", locked, err_cnt, err_step(e0));
                end
            end
        end
        frame(1'b0);
        n_tests++;
        if (err_cnt !== 8'(err_step(e0))) begin
            n_fail++;
            $display("FAIL timeout_once: err=%0d, required %0d", err_cnt, err_step(e0));
        end
    endtask

    task automatic test_mid_reset();
        for (int f = 0; f < 4; f++) frame(1'b0);
        check_lock("mid_reset_pre", 1'b1);
        for (int l = 0; l < 10; l++) line(HT, (l < 2) ? 1 : 0);
        for (int i = 0; i < HVS + 2; i++) cyc(i >= HSW, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b1);
        check_zero("mid_reset");
        frame(1'b0);
        frame(1'b0);
        check_lock("no_partial_lock", 1'b0);
        frame(1'b0);
        check_lock("reacquire", 1'b1);
    endtask

    task automatic test_late_vsync();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) frame(1'b1);
        check_lock("late_vsync", 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) != 0), 1'b0);
        for (int k = 0; k < 60; k++)
            line(HT - 1 + $urandom_range(0, 2), $urandom_range(0, 3));
        for (int f = 0; f < 4; f++) frame($urandom_range(0, 1) == 1);
    endtask

    task automatic test_bad_lines();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 540; n++) line(30, 3);
        n_tests++;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate: err=%0d, required 255", err_cnt);
        end
`else
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL err_disabled: err=%0d, required 0", err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_coincident();
        test_short_line();
        test_timeout();
        test_mid_reset();
        test_late_vsync();
        test_random();
        test_bad_lines();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
